// File: rtl/priority_encoder_16to4.sv
// Sequential 16-to-4 priority encoder with sticky request latching and a valid/ack handshake.
// Define PRIORITY_ENCODER_ROUND_ROBIN_EN for rotating priority; otherwise the lowest index wins.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no index presented; grant from Pending | Req_In when nonzero
// PRESENT | Enc_Out holds a granted index until Enc_Ack
module priority_encoder_16to4 (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [15:0] Req_In,
    input  logic        Enc_Ack,
    output logic [3:0]  Enc_Out,
    output logic        Enc_Valid,
    output logic [15:0] Pending
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic [3:0]  enc_out_q, enc_out_d;
    logic        enc_valid_q, enc_valid_d;
    logic [15:0] cand;
    logic [3:0]  search_base;
    logic [3:0]  winner;
    logic        found;

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
    logic [3:0] ptr_q, ptr_d;

    assign search_base = ptr_q;
`else
    assign search_base = 4'd0;
`endif

    assign cand = pending_q | Req_In;

    // First set bit scanning upward from search_base, wrapping 15 -> 0.
    always_comb begin
        logic [3:0] idx;
        winner = 4'd0;
        found  = 1'b0;
        idx    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx = search_base + i[3:0];
            if (!found && cand[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        enc_out_d   = enc_out_q;
        enc_valid_d = enc_valid_q;
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                pending_d = cand;
                if (found) begin
                    pending_d[winner] = 1'b0;
                    enc_out_d         = winner;
                    enc_valid_d       = 1'b1;
                    state_d           = PRESENT;
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
                    ptr_d             = winner + 4'd1;
`endif
                end
            end
            PRESENT: begin
                // A re-request of the presented index re-pends rather than merging into it.
                pending_d = cand;
                if (Enc_Ack) begin
                    enc_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                enc_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            pending_q   <= 16'h0000;
            enc_out_q   <= 4'h0;
            enc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            enc_out_q   <= enc_out_d;
            enc_valid_q <= enc_valid_d;
        end
    end

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ptr_q <= 4'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign Enc_Out   = enc_out_q;
    assign Enc_Valid = enc_valid_q;
    assign Pending   = pending_q;

endmodule

// File: doc/priority_encoder_16to4.md
# priority_encoder_16to4

Sequential 16-to-4 priority encoder: the inverse of the one-hot 4-to-16 decoder. It latches up to 16 request lines, presents the winning line as a 4-bit index with a valid/ack handshake, and clears each request once it has been consumed. It sits between one-hot sources (register write strobes, paddle/ball event lines, interrupt-style flags) and the CPU datapath that needs a binary index.

## Interface
- No parameters; widths are fixed at 16 requests and a 4-bit index.
- Clk  input  1  single clock, rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- Req_In  input  16  request lines, level-sampled each edge; any 1 bit sets the sticky pending bit.
- Enc_Ack  input  1  consumer accepts the presented index; only meaningful while Enc_Valid=1.
- Enc_Out  output  4  index of the granted request, registered.
- Enc_Valid  output  1  Enc_Out holds a granted, unacknowledged index.
- Pending  output  16  current sticky pending register (excludes the index being presented).

## Operation
- Reset (Rst_n=0 at an edge): Pending=16'h0000, Enc_Out=4'h0, Enc_Valid=0, state IDLE, round-robin pointer=0. Req_In and Enc_Ack are ignored on that edge.
- Candidate set at each edge = Pending | Req_In.
- State IDLE:
  - Candidate set is zero: remain in IDLE.
  - Candidate set is nonzero: select the winner, load Enc_Out with it, set Enc_Valid=1, and go to PRESENT.
  - Pending takes (candidate set) with the winner bit cleared.
- State PRESENT:
  - Enc_Out is held stable.
  - Pending |= Req_In every edge, including any Req_In bit equal to Enc_Out; that bit re-pends.
  - Enc_Ack=1 at an edge: Enc_Valid=0 and go to IDLE.
- Enc_Ack while Enc_Valid=0 is ignored and has no side effects.
- Winner selection, fixed priority: the lowest set index wins, so bit 0 is highest priority.
- Pending is never lost: a request is dropped only by being granted or by reset.
- Pending and the output registers are all 16/4 bits; the index never exceeds 4'hF. No X is ever driven.

## Timing
- Latency: Req_In[i] high before edge k with state IDLE and no higher-priority candidate gives Enc_Valid=1 and Enc_Out=i after edge k.
- Ack at edge m drops Enc_Valid after edge m. The next grant is issued at edge m+1 at the earliest, so there is a one-cycle bubble and a maximum throughput of one index per 2 cycles.
- A request arriving in the same cycle as an ack is latched into Pending at edge m and is eligible at edge m+1.
- Reset mid-PRESENT clears everything on that edge. The consumer must treat Enc_Valid=0 as an abort.
- Outputs are glitch-free registers; nothing in this block is combinational from input to output.

## Configuration
- Macro: PRIORITY_ENCODER_ROUND_ROBIN_EN.
- Undefined: fixed priority (lowest index wins); the pointer register is not built.
- Defined: rotating priority.
  - The search starts at the pointer and wraps 15 -> 0.
  - On each grant, the pointer becomes (winner + 1) mod 16, so 4'hF wraps to 0.
  - Reset pointer = 0, so the first grant after reset matches fixed priority.

## Test plan
- Reset: hold Rst_n=0 with Req_In=16'hFFFF for 3 cycles -> Enc_Valid=0, Enc_Out=0, Pending=0 throughout; the first grant occurs at the first edge with Rst_n=1.
- Single request: pulse Req_In=16'h0400 for one cycle -> Enc_Out=4'hA and Enc_Valid=1 the next cycle, held until Enc_Ack; Pending=0.
- Multi-request, fixed priority: Req_In=16'h8011 for one cycle, ack every presentation -> grants 0, 4, 15 in order, each separated by one idle cycle; Pending goes 16'h8010 -> 16'h8000 -> 0.
- Simultaneous ack and re-request: while presenting 3, assert Enc_Ack with Req_In=16'h0008 -> Enc_Valid drops, Pending bit 3=1, and 3 is re-granted the following edge.
- Spurious ack: Enc_Ack=1 with Enc_Valid=0 and Pending=0 -> no state change.
- Round robin (macro defined): hold Req_In=16'h8001 continuously, ack immediately -> grants alternate 0, 15, 0, 15; the pointer wraps 4'hF -> 0.
